// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: configurable word width, SCLK divider,
// all four CPOL/CPHA modes, MSB/LSB-first order and multiple chip selects.
module spi_master_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned CS_NUM    = 1,
  parameter int unsigned CS_W      = 1,
  parameter int unsigned LSB_FIRST = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        mode_bi,
  input  logic [CS_W-1:0]   cs_sel_bi,
  input  logic [DATA_W-1:0] data_in_bi,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] data_out_bo,
  input  logic              spi_miso_i,
  output logic              spi_mosi_o,
  output logic              spi_sclk_o,
  output logic [CS_NUM-1:0] spi_cs_bo
);

  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned EDGE_NUM = 2 * DATA_W;
  localparam int unsigned EDGE_W   = $clog2(EDGE_NUM + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                cpha_q, cpha_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                mosi_q, mosi_d;
  logic                sclk_q, sclk_d;
  logic [CS_NUM-1:0]   cs_q, cs_d;

  logic div_last;
  logic leading;
  logic last_edge;
  logic cs_ok;

  // Bit that leaves the word first in the configured order.
  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  // Received bits enter at the opposite end so the final word is never reversed.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
    return (LSB_FIRST != 0) ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  function automatic logic [CS_NUM-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [CS_NUM-1:0] m;
    m = '1;
    for (int unsigned i = 0; i < CS_NUM; i++) begin
      if (32'(sel) == i) m[i] = 1'b0;
    end
    return m;
  endfunction

  assign div_last  = (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign leading   = ~edge_cnt_q[0];
  assign last_edge = (edge_cnt_q == EDGE_W'(EDGE_NUM - 1));
  assign cs_ok     = (32'(cs_sel_bi) < CS_NUM);

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      data_out_q <= '0;
      cpha_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mosi_q     <= 1'b0;
      sclk_q     <= 1'b0;
      cs_q       <= '1;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      data_out_q <= data_out_d;
      cpha_q     <= cpha_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mosi_q     <= mosi_d;
      sclk_q     <= sclk_d;
      cs_q       <= cs_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    data_out_d = data_out_q;
    cpha_d     = cpha_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mosi_d     = mosi_q;
    sclk_d     = sclk_q;
    cs_d       = cs_q;

    case (state_q)
      ST_IDLE: begin
        sclk_d = mode_bi[1];
        if (start_i && cs_ok) begin
          state_d    = ST_SETUP;
          busy_d     = 1'b1;
          cpha_d     = mode_bi[0];
          cs_d       = cs_decode(cs_sel_bi);
          div_cnt_d  = '0;
          edge_cnt_d = '0;
          rx_sr_d    = '0;
          // CPHA=0 must have the first bit on the line before the first edge.
          if (mode_bi[0]) begin
            mosi_d  = 1'b0;
            tx_sr_d = data_in_bi;
          end else begin
            mosi_d  = head_bit(data_in_bi);
            tx_sr_d = shift_out(data_in_bi);
          end
        end
      end

      ST_SETUP: begin
        if (div_last) begin
          div_cnt_d = '0;
          state_d   = ST_XFER;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      ST_XFER: begin
        if (div_last) begin
          div_cnt_d  = '0;
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_cnt_q + EDGE_W'(1);
          // Sample on leading edges for CPHA=0, trailing edges for CPHA=1; drive on the other.
          if (leading ^ cpha_q) begin
            rx_sr_d = shift_in(rx_sr_q, spi_miso_i);
          end else if (!last_edge) begin
            mosi_d  = head_bit(tx_sr_q);
            tx_sr_d = shift_out(tx_sr_q);
          end
          if (last_edge) state_d = ST_HOLD;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      ST_HOLD: begin
        if (div_last) begin
          div_cnt_d = '0;
          state_d   = ST_GAP;
          cs_d      = '1;
          mosi_d    = 1'b0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      ST_GAP: begin
        if (div_last) begin
          div_cnt_d  = '0;
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          data_out_d = rx_sr_q;
          busy_d     = 1'b0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign data_out_bo = data_out_q;
  assign spi_mosi_o  = mosi_q;
  assign spi_sclk_o  = sclk_q;
  assign spi_cs_bo   = cs_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param: behavioural SPI slave / line monitor
// checks two configurations (MSB-first 3-CS, and LSB-first 12-bit loopback).
module tb_spi_master_param;

  localparam int unsigned DW    = 8;
  localparam int unsigned CD    = 2;
  localparam int unsigned CSN   = 3;
  localparam int unsigned CSW   = 2;
  localparam int unsigned LW    = 12;
  localparam int unsigned LCD   = 3;
  localparam int unsigned LAT_A = 1 + (2 * DW + 3) * CD;
  localparam int unsigned LAT_B = 1 + (2 * LW + 3) * LCD;
  localparam int unsigned TMO   = 2000;

  typedef struct {
    logic [15:0] tx;
    logic [15:0] word;
    logic [1:0]  mode;
    int          sel;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  int   pushed_a = 0, pushed_b = 0, dones_a = 0, dones_b = 0;

  logic           start_a, busy_a, done_a, mosi_a, sclk_a, miso_a;
  logic [1:0]     mode_a;
  logic [CSW-1:0] sel_a;
  logic [DW-1:0]  din_a, dout_a;
  logic [CSN-1:0] cs_a;

  logic           start_b, busy_b, done_b, mosi_b, sclk_b;
  logic [1:0]     mode_b;
  logic [0:0]     sel_b, cs_b;
  logic [LW-1:0]  din_b, dout_b;

  logic [DW-1:0]  slave_word;
  logic [1:0]     slave_mode;
  logic [1:0]     slave_mode_b;

  spi_master_param #(.DATA_W(DW), .CLK_DIV(CD), .CS_NUM(CSN), .CS_W(CSW), .LSB_FIRST(0)) u_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .mode_bi(mode_a), .cs_sel_bi(sel_a),
    .data_in_bi(din_a), .busy_o(busy_a), .done_o(done_a), .data_out_bo(dout_a),
    .spi_miso_i(miso_a), .spi_mosi_o(mosi_a), .spi_sclk_o(sclk_a), .spi_cs_bo(cs_a)
  );

  spi_master_param #(.DATA_W(LW), .CLK_DIV(LCD), .CS_NUM(1), .CS_W(1), .LSB_FIRST(1)) u_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .mode_bi(mode_b), .cs_sel_bi(sel_b),
    .data_in_bi(din_b), .busy_o(busy_b), .done_o(done_b), .data_out_bo(dout_b),
    .spi_miso_i(mosi_b), .spi_mosi_o(mosi_b), .spi_sclk_o(sclk_b), .spi_cs_bo(cs_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endfunction

  // Slave model and monitor for DUT A.
  logic          s_act = 1'b0, sclk_prev_a = 1'b0, busy_prev_a = 1'b0;
  int            s_bit = 0, tog_a = 0, cs_cnt_a = 0, acc_a = 0;
  logic [DW-1:0] s_rx = '0, s_tx = '0;
  logic [1:0]    s_mode = '0;
  logic [CSN-1:0] cs_mask_a = '0;

  always @(negedge clk) begin
    logic cs_any, lead;
    exp_t e;
    cs_any = (cs_a != '1);
    if (rst) begin
      s_act = 1'b0; tog_a = 0; cs_cnt_a = 0; cs_mask_a = '0; miso_a = 1'b0; s_bit = 0;
    end else begin
      if (busy_a && !busy_prev_a) acc_a = cyc;
      if (cs_any) begin
        cs_cnt_a++;
        cs_mask_a |= ~cs_a;
      end
      if (cs_any && !s_act) begin
        s_bit = 0; s_rx = '0; s_tx = slave_word; s_mode = slave_mode;
        miso_a = s_mode[0] ? 1'b0 : s_tx[DW-1];
      end else if (cs_any && sclk_a != sclk_prev_a) begin
        tog_a++;
        lead = (sclk_a != s_mode[1]);
        if (lead ^ s_mode[0]) begin
          s_rx[DW-1-s_bit] = mosi_a;
          s_bit++;
        end else if (s_bit < int'(DW)) begin
          miso_a = s_tx[DW-1-s_bit];
        end
      end
      if (done_a) begin
        if (sb_a.size() == 0) begin
          chk("a_unexpected_done", 32'(1), 32'(0));
        end else begin
          e = sb_a.pop_front();
          chk("a_data_out", 32'(dout_a), 32'(e.word[DW-1:0]));
          chk("a_slave_rx", 32'(s_rx), 32'(e.tx[DW-1:0]));
          chk("a_latency", 32'(cyc - acc_a + 1), 32'(LAT_A));
          chk("a_sclk_toggles", 32'(tog_a), 32'(2 * DW));
          chk("a_cs_low_cycles", 32'(cs_cnt_a), 32'((2 * DW + 2) * CD));
          chk("a_cs_lines_low", 32'(cs_mask_a), 32'(1) << e.sel);
          chk("a_sclk_idle_cpol", 32'(sclk_a), 32'(e.mode[1]));
        end
        dones_a++;
        tog_a = 0; cs_cnt_a = 0; cs_mask_a = '0;
      end
    end
    s_act = cs_any; sclk_prev_a = sclk_a; busy_prev_a = busy_a;
  end

  // Line monitor for the loopback DUT B.
  logic          b_act = 1'b0, sclk_prev_b = 1'b0, busy_prev_b = 1'b0;
  int            b_bit = 0, acc_b = 0;
  logic [LW-1:0] b_cap = '0;
  logic [1:0]    b_mode = '0;

  always @(negedge clk) begin
    logic lead;
    exp_t e;
    if (rst) begin
      b_act = 1'b0; b_bit = 0;
    end else begin
      if (busy_b && !busy_prev_b) acc_b = cyc;
      if (!cs_b[0] && !b_act) begin
        b_bit = 0; b_cap = '0; b_mode = slave_mode_b;
      end else if (!cs_b[0] && sclk_b != sclk_prev_b) begin
        lead = (sclk_b != b_mode[1]);
        if ((lead ^ b_mode[0]) && b_bit < int'(LW)) begin
          b_cap[b_bit] = mosi_b;
          b_bit++;
        end
      end
      if (done_b) begin
        if (sb_b.size() == 0) begin
          chk("b_unexpected_done", 32'(1), 32'(0));
        end else begin
          e = sb_b.pop_front();
          chk("b_data_out", 32'(dout_b), 32'(e.tx[LW-1:0]));
          chk("b_mosi_lsb_first", 32'(b_cap), 32'(e.tx[LW-1:0]));
          chk("b_bits_sampled", 32'(b_bit), 32'(LW));
          chk("b_latency", 32'(cyc - acc_b + 1), 32'(LAT_B));
        end
        dones_b++;
      end
    end
    b_act = !cs_b[0]; sclk_prev_b = sclk_b; busy_prev_b = busy_b;
  end

  task automatic issue_a(input logic [DW-1:0] tx, input logic [DW-1:0] word,
                         input logic [1:0] mode, input int sel);
    exp_t e;
    slave_word = word; slave_mode = mode;
    din_a = tx; mode_a = mode; sel_a = CSW'(sel);
    e.tx = 16'(tx); e.word = 16'(word); e.mode = mode; e.sel = sel;
    sb_a.push_back(e);
    pushed_a++;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a();
    int n;
    n = 0;
    while (!done_a && n < int'(TMO)) begin
      @(negedge clk);
      n++;
    end
    if (n >= int'(TMO)) chk("a_done_timeout", 32'(0), 32'(1));
  endtask

  task automatic run_b(input logic [LW-1:0] tx, input logic [1:0] mode);
    exp_t e;
    int n;
    slave_mode_b = mode; din_b = tx; mode_b = mode;
    e.tx = 16'(tx); e.word = 16'(tx); e.mode = mode; e.sel = 0;
    sb_b.push_back(e);
    pushed_b++;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < int'(TMO)) begin
      @(negedge clk);
      n++;
    end
    if (n >= int'(TMO)) chk("b_done_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen, gap, extra;
    int dc[3];
    rst = 1'b1;
    start_a = 1'b0; mode_a = '0; sel_a = '0; din_a = '0;
    start_b = 1'b0; mode_b = '0; sel_b = '0; din_b = '0;
    slave_word = '0; slave_mode = '0; slave_mode_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_a), 32'(0));
    chk("rst_done", 32'(done_a), 32'(0));
    chk("rst_data_out", 32'(dout_a), 32'(0));
    chk("rst_cs", 32'(cs_a), 32'((1 << CSN) - 1));
    chk("rst_sclk", 32'(sclk_a), 32'(0));
    chk("rst_mosi", 32'(mosi_a), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Mode 0 reference transfer, then the other three modes.
    issue_a(8'hAC, 8'h65, 2'd0, 0);
    wait_done_a();
    for (int m = 1; m < 4; m++) begin
      issue_a(8'h99, 8'h28, 2'(m), m % int'(CSN));
      wait_done_a();
    end

    // Random transfers across all modes and chip selects.
    for (int i = 0; i < 8; i++) begin
      issue_a(DW'($urandom), DW'($urandom), 2'($urandom_range(0, 3)),
              int'($urandom_range(0, CSN - 1)));
      wait_done_a();
    end

    // Out-of-range chip select is ignored.
    @(negedge clk);
    sel_a = CSW'(3); start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("badsel_busy", 32'(busy_a), 32'(0));
    chk("badsel_cs", 32'(cs_a), 32'((1 << CSN) - 1));
    repeat (5) @(negedge clk);
    chk("badsel_busy_later", 32'(busy_a), 32'(0));

    // start pulses while busy must not create transfers.
    issue_a(8'h5A, 8'hC1, 2'd3, 1);
    repeat (6) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      din_a = DW'($urandom); sel_a = CSW'(0); start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (4) @(negedge clk);
    end
    wait_done_a();
    repeat (LAT_A + 5) @(negedge clk);
    chk("busy_pulse_no_extra", 32'(dones_a), 32'(pushed_a));

    // start held high: three back-to-back transfers.
    slave_word = 8'h3C; slave_mode = 2'd1;
    din_a = 8'hC3; mode_a = 2'd1; sel_a = CSW'(2);
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.tx = 16'h00C3; e.word = 16'h003C; e.mode = 2'd1; e.sel = 2;
      sb_a.push_back(e);
      pushed_a++;
    end
    start_a = 1'b1;
    n = 0; seen = 0; gap = 0;
    while (seen < 3 && n < int'(4 * LAT_A)) begin
      @(negedge clk);
      n++;
      if (done_a) begin
        dc[seen] = cyc;
        seen++;
        if (seen == 3) start_a = 1'b0;
      end
      if (seen >= 1 && seen < 3 && cs_a == '1) gap++;
    end
    start_a = 1'b0;
    chk("held_done_count", 32'(seen), 32'(3));
    chk("held_spacing_1", 32'(dc[1] - dc[0]), 32'(LAT_A));
    chk("held_spacing_2", 32'(dc[2] - dc[1]), 32'(LAT_A));
    chk("held_cs_high_cycles", 32'(gap), 32'(2 * (CD + 1)));
    repeat (LAT_A + 5) @(negedge clk);
    chk("held_stops", 32'(busy_a), 32'(0));

    // Reset during bit 4 aborts the transfer.
    issue_a(8'hE7, 8'h81, 2'd2, 1);
    n = 0;
    while (s_bit < 4 && n < int'(TMO)) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cs", 32'(cs_a), 32'((1 << CSN) - 1));
    chk("abort_sclk", 32'(sclk_a), 32'(0));
    chk("abort_busy", 32'(busy_a), 32'(0));
    chk("abort_data_out", 32'(dout_a), 32'(0));
    chk("abort_done", 32'(done_a), 32'(0));
    rst = 1'b0;
    sb_a.delete();
    sb_b.delete();
    pushed_a--;
    extra = 0;
    repeat (LAT_A + 5) begin
      @(negedge clk);
      if (done_a) extra++;
    end
    chk("abort_no_done", 32'(extra), 32'(0));
    issue_a(8'h3E, 8'hD4, 2'd0, 2);
    wait_done_a();

    // LSB-first 12-bit loopback.
    @(negedge clk);
    run_b(12'hA5C, 2'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      run_b(LW'($urandom), 2'(i + 1));
    end

    repeat (10) @(negedge clk);
    chk("a_scoreboard_empty", 32'(sb_a.size()), 32'(0));
    chk("a_done_count", 32'(dones_a), 32'(pushed_a));
    chk("b_scoreboard_empty", 32'(sb_b.size()), 32'(0));
    chk("b_done_count", 32'(dones_b), 32'(pushed_b));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised next-generation SPI master controller. Adds configurable word width, SCLK divider, all four CPOL/CPHA modes, MSB/LSB-first order and multiple chip selects. Sits between a register or bus front-end and external SPI slaves, including the existing slave driver on the same clock. Full-duplex: one word shifted out on MOSI while one word is shifted in from MISO.

Parameters:
DATA_W, 8, bits per transfer; must be >= 2
CLK_DIV, 2, system clock cycles per SCLK half-period; must be >= 1
CS_NUM, 1, number of chip-select lines; must be >= 1
CS_W, 1, width of cs_sel_bi, equal to max(1, clog2(CS_NUM))
LSB_FIRST, 0, 0 = MSB first on both lines, 1 = LSB first

Ports:
clk_i  in  1  system clock; all logic on rising edge
rst_i  in  1  reset, synchronous, active-high
start_i  in  1  transfer request; sampled only while busy_o=0
mode_bi  in  2  [1]=CPOL, [0]=CPHA; latched on accepted start
cs_sel_bi  in  CS_W  index of the slave to select; latched on accepted start
data_in_bi  in  DATA_W  word to transmit; latched on accepted start
busy_o  out  1  high from the cycle after accept until the done cycle
done_o  out  1  one-cycle pulse when the transfer completes
data_out_bo  out  DATA_W  last received word; held until the next done
spi_miso_i  in  1  serial data from slave, same clock domain, no synchroniser
spi_mosi_o  out  1  serial data to slave
spi_sclk_o  out  1  serial clock
spi_cs_bo  out  CS_NUM  active-low chip selects; at most one low at a time

Behaviour:
- Reset (sync, any state) takes effect at the next edge:
  - busy_o=0, done_o=0, data_out_bo=0, mosi=0, sclk=0, spi_cs_bo all ones, state=IDLE
  - In-flight transfer is aborted. data_out_bo is not updated and no done_o pulse is produced.
- States: IDLE, SETUP, XFER, HOLD, GAP.
- IDLE:
  - spi_sclk_o is registered each cycle from mode_bi[1].
  - Accept condition: start_i=1 and cs_sel_bi<CS_NUM.
  - On accept: latch data, mode and cs_sel. Next edge: busy_o=1, selected CS goes low, state goes to SETUP.
  - start_i with cs_sel_bi>=CS_NUM is ignored: no busy, no CS.
- SETUP (CLK_DIV cycles):
  - SCLK stays at CPOL.
  - If CPHA=0, MOSI presents the first bit on entry. If CPHA=1, MOSI is 0.
- XFER (2*DATA_W half-periods of CLK_DIV cycles each):
  - SCLK toggles at each half-period boundary. Odd toggles are leading edges; even toggles are trailing edges.
  - CPHA=0: sample MISO on the leading edge; drive the next bit on the trailing edge. No drive after the final trailing edge.
  - CPHA=1: drive a bit on the leading edge; sample MISO on the trailing edge.
  - After the final trailing edge, SCLK is back at CPOL and the state goes to HOLD.
- HOLD (CLK_DIV cycles): CS stays low, SCLK=CPOL, MOSI holds its last value.
- GAP (CLK_DIV cycles):
  - All CS lines high, MOSI=0.
  - On the last GAP cycle edge: done_o=1 for one cycle, data_out_bo takes the received word, busy_o=0, state goes to IDLE.
- Latency: done_o is high exactly 1+(2*DATA_W+3)*CLK_DIV cycles after the edge that accepted start_i. With defaults this is 39.
- Back-to-back: start_i asserted in the done cycle is accepted. Minimum CS-high time is therefore CLK_DIV+1 cycles.
- start_i while busy_o=1 is ignored. Latched inputs cannot change mid-transfer.
- Bit order:
  - LSB_FIRST=0: bit DATA_W-1 is sent/received first.
  - LSB_FIRST=1: bit 0 is sent/received first.
  - Received bits land in the mirrored positions so data_out_bo is never bit-reversed.
- start_i held high continuously: a new transfer is accepted after every done.

Test Plan:
- Mode 0, defaults, loopback slave holding 0x65, master sends 0xAC, start pulsed 1 cycle -> MOSI bit stream 1,0,1,0,1,1,0,0; slave receives 0xAC; data_out_bo=0x65 with done_o at cycle 39; exactly 8 rising SCLK edges; CS[0] low for 36 cycles.
- Modes 1/2/3, DATA_W=8, CLK_DIV=3, send 0x99 to slave holding 0x28 -> data_out_bo=0x28 in every mode; idle SCLK equals CPOL; sample edge matches the CPHA rule; done at cycle 58.
- LSB_FIRST=1, DATA_W=12, send 0xA5C -> MOSI order 0,0,1,1,1,0,1,0,0,1,0,1; loopback (MISO tied to MOSI) gives data_out_bo=0xA5C.
- CS_NUM=4: cs_sel=2 -> only spi_cs_bo[2] goes low. cs_sel=5 with CS_W=3 -> start ignored, busy_o stays 0, all CS high.
- start_i held high for 3 transfers -> 3 done pulses spaced 39 cycles apart (defaults); CS high for 3 cycles between words; start_i pulses during busy produce no extra transfers.
- rst_i asserted during bit 4 of a transfer -> next edge: CS all high, SCLK=0, busy_o=0, data_out_bo=0, no done_o; a new start after reset completes normally.
